// File: rtl/point_cloud_loader_if.sv
// Point-stream handshake bundle between the host stream endpoints and point_cloud_loader.
// master = host side (drives s_*, m_ready); slave = loader side.
interface point_cloud_loader_if #(
  parameter int unsigned N = 16
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_x;
  logic [N-1:0] s_y;
  logic [N-1:0] s_z;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_x;
  logic [N-1:0] m_y;
  logic [N-1:0] m_z;

  modport master (
    output s_valid, s_x, s_y, s_z, s_last, m_ready,
    input  s_ready, m_valid, m_x, m_y, m_z
  );

  modport slave (
    input  s_valid, s_x, s_y, s_z, s_last, m_ready,
    output s_ready, m_valid, m_x, m_y, m_z
  );
endinterface

// File: rtl/point_cloud_loader.sv
// Host-side loader for the BRAM point-cloud filter engine: packs points, starts the engine,
// polls for completion and streams the result back. Optional DROP_OUTLIERS_EN hides zeroed points.
module point_cloud_loader #(
  parameter int unsigned N             = 16,
  parameter int unsigned BUS_SIZE      = 32,
  parameter int unsigned MAX_POINTS    = 65536,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                clock,
  input  logic                reset,
  point_cloud_loader_if.slave strm,
  output logic                unload_done,
  output logic                busy,
  output logic [31:0]         addr_x,
  output logic [31:0]         addr_y,
  output logic [31:0]         addr_z,
  output logic [BUS_SIZE-1:0] write_in_x,
  output logic [BUS_SIZE-1:0] write_in_y,
  output logic [BUS_SIZE-1:0] write_in_z,
  input  logic [BUS_SIZE-1:0] read_out_x,
  input  logic [BUS_SIZE-1:0] read_out_y,
  input  logic [BUS_SIZE-1:0] read_out_z,
  output logic                en_x,
  output logic                en_y,
  output logic                en_z,
  output logic [3:0]          we_x,
  output logic [3:0]          we_y,
  output logic [3:0]          we_z
);

  localparam int unsigned PollW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [BUS_SIZE-1:0] DoneMarker = BUS_SIZE'(32'h0000_0fff);

  typedef enum logic [3:0] {
    StIdle, StLoad, StFlush, StHdrA, StHdrB, StWait,
    StRdA, StRdB, StLo, StHi, StClear
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         count_q, count_d;
  logic                half_q, half_d;
  logic [N-1:0]        hx_q, hx_d, hy_q, hy_d, hz_q, hz_d;
  logic [PollW-1:0]    poll_q, poll_d;
  logic [1:0]          chk_q, chk_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         idx_q, idx_d;
  logic [BUS_SIZE-1:0] bx_q, bx_d, by_q, by_d, bz_q, bz_d;

  logic [31:0]         addr_x_q, addr_x_d, addr_y_q, addr_y_d, addr_z_q, addr_z_d;
  logic [BUS_SIZE-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_z_q, wr_z_d;
  logic                en_x_q, en_x_d, en_y_q, en_y_d, en_z_q, en_z_d;
  logic [3:0]          we_x_q, we_x_d, we_y_q, we_y_d, we_z_q, we_z_d;

  logic [N-1:0] pt_x, pt_y, pt_z;
  logic         in_pres, m_valid_int, xfer, last_pt;

  assign in_pres = (state_q == StLo) || (state_q == StHi);
  assign pt_x    = (state_q == StHi) ? bx_q[2*N-1:N] : bx_q[N-1:0];
  assign pt_y    = (state_q == StHi) ? by_q[2*N-1:N] : by_q[N-1:0];
  assign pt_z    = (state_q == StHi) ? bz_q[2*N-1:N] : bz_q[N-1:0];
  assign last_pt = (idx_q == count_q - 32'd1);

`ifdef DROP_OUTLIERS_EN
  logic pt_zero;
  assign pt_zero     = (pt_x == '0) && (pt_y == '0) && (pt_z == '0);
  assign m_valid_int = in_pres && !pt_zero;
  // Zeroed outliers are retired in one cycle without waiting for the sink.
  assign xfer        = in_pres && (pt_zero || strm.m_ready);
`else
  assign m_valid_int = in_pres;
  assign xfer        = in_pres && strm.m_ready;
`endif

  assign strm.s_ready = (state_q == StIdle) || (state_q == StLoad);
  assign strm.m_valid = m_valid_int;
  assign strm.m_x     = pt_x;
  assign strm.m_y     = pt_y;
  assign strm.m_z     = pt_z;
  assign busy         = (state_q != StIdle);
  assign unload_done  = (state_q == StClear);

  assign addr_x     = addr_x_q;
  assign addr_y     = addr_y_q;
  assign addr_z     = addr_z_q;
  assign write_in_x = wr_x_q;
  assign write_in_y = wr_y_q;
  assign write_in_z = wr_z_q;
  assign en_x       = en_x_q;
  assign en_y       = en_y_q;
  assign en_z       = en_z_q;
  assign we_x       = we_x_q;
  assign we_y       = we_y_q;
  assign we_z       = we_z_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    half_d   = half_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    hz_d     = hz_q;
    poll_d   = poll_q;
    chk_d    = chk_q;
    word_d   = word_q;
    idx_d    = idx_q;
    bx_d     = bx_q;
    by_d     = by_q;
    bz_d     = bz_q;
    addr_x_d = '0;
    addr_y_d = '0;
    addr_z_d = '0;
    wr_x_d   = '0;
    wr_y_d   = '0;
    wr_z_d   = '0;
    en_x_d   = 1'b0;
    en_y_d   = 1'b0;
    en_z_d   = 1'b0;
    we_x_d   = 4'h0;
    we_y_d   = 4'h0;
    we_z_d   = 4'h0;

    unique case (state_q)
      StIdle: begin
        if (strm.s_valid) begin
          hx_d    = strm.s_x;
          hy_d    = strm.s_y;
          hz_d    = strm.s_z;
          half_d  = 1'b1;
          count_d = 32'd1;
          state_d = (strm.s_last || (32'(MAX_POINTS) <= 32'd1)) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        if (strm.s_valid) begin
          count_d = count_q + 32'd1;
          if (half_q) begin
            en_x_d   = 1'b1;
            en_y_d   = 1'b1;
            en_z_d   = 1'b1;
            we_x_d   = 4'hf;
            we_y_d   = 4'hf;
            we_z_d   = 4'hf;
            addr_x_d = 32'd1 + {1'b0, count_q[31:1]};
            addr_y_d = 32'd1 + {1'b0, count_q[31:1]};
            addr_z_d = 32'd1 + {1'b0, count_q[31:1]};
            wr_x_d   = BUS_SIZE'({strm.s_x, hx_q});
            wr_y_d   = BUS_SIZE'({strm.s_y, hy_q});
            wr_z_d   = BUS_SIZE'({strm.s_z, hz_q});
            half_d   = 1'b0;
          end else begin
            hx_d   = strm.s_x;
            hy_d   = strm.s_y;
            hz_d   = strm.s_z;
            half_d = 1'b1;
          end
          if (strm.s_last || (count_d == 32'(MAX_POINTS))) state_d = StFlush;
        end
      end
      StFlush: begin
        // Odd count leaves one point parked in the low-half registers.
        if (half_q) begin
          en_x_d   = 1'b1;
          en_y_d   = 1'b1;
          en_z_d   = 1'b1;
          we_x_d   = 4'hf;
          we_y_d   = 4'hf;
          we_z_d   = 4'hf;
          addr_x_d = 32'd1 + {1'b0, count_q[31:1]};
          addr_y_d = 32'd1 + {1'b0, count_q[31:1]};
          addr_z_d = 32'd1 + {1'b0, count_q[31:1]};
          wr_x_d   = BUS_SIZE'({{N{1'b0}}, hx_q});
          wr_y_d   = BUS_SIZE'({{N{1'b0}}, hy_q});
          wr_z_d   = BUS_SIZE'({{N{1'b0}}, hz_q});
          half_d   = 1'b0;
        end
        state_d = StHdrA;
      end
      StHdrA: begin
        en_x_d  = 1'b1;
        we_x_d  = 4'hf;
        wr_x_d  = BUS_SIZE'(count_q);
        en_z_d  = 1'b1;
        we_z_d  = 4'hf;
        state_d = StHdrB;
      end
      StHdrB: begin
        en_y_d  = 1'b1;
        we_y_d  = 4'hf;
        wr_y_d  = BUS_SIZE'(32'd1);
        poll_d  = '0;
        chk_d   = 2'b00;
        state_d = StWait;
      end
      StWait: begin
        // chk_q[1] marks the cycle in which the polled z[0] word is on read_out_z.
        chk_d = {chk_q[0], 1'b0};
        if (poll_q == PollW'(POLL_INTERVAL - 1)) begin
          poll_d   = '0;
          en_z_d   = 1'b1;
          chk_d[0] = 1'b1;
        end else begin
          poll_d = poll_q + 1'b1;
        end
        if (chk_q[1] && (read_out_z == DoneMarker)) begin
          en_x_d   = 1'b1;
          en_y_d   = 1'b1;
          en_z_d   = 1'b1;
          addr_x_d = 32'd1;
          addr_y_d = 32'd1;
          addr_z_d = 32'd1;
          word_d   = 32'd1;
          idx_d    = '0;
          chk_d    = 2'b00;
          state_d  = StRdA;
        end
      end
      StRdA: state_d = StRdB;
      StRdB: begin
        bx_d    = read_out_x;
        by_d    = read_out_y;
        bz_d    = read_out_z;
        state_d = StLo;
      end
      StLo, StHi: begin
        if (xfer) begin
          idx_d = idx_q + 32'd1;
          if (last_pt) begin
            en_y_d  = 1'b1;
            en_z_d  = 1'b1;
            we_y_d  = 4'hf;
            we_z_d  = 4'hf;
            state_d = StClear;
          end else if (state_q == StLo) begin
            state_d = StHi;
          end else begin
            en_x_d   = 1'b1;
            en_y_d   = 1'b1;
            en_z_d   = 1'b1;
            addr_x_d = word_q + 32'd1;
            addr_y_d = word_q + 32'd1;
            addr_z_d = word_q + 32'd1;
            word_d   = word_q + 32'd1;
            state_d  = StRdA;
          end
        end
      end
      StClear: begin
        count_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      half_q   <= 1'b0;
      hx_q     <= '0;
      hy_q     <= '0;
      hz_q     <= '0;
      poll_q   <= '0;
      chk_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      bz_q     <= '0;
      addr_x_q <= '0;
      addr_y_q <= '0;
      addr_z_q <= '0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_z_q   <= '0;
      en_x_q   <= 1'b0;
      en_y_q   <= 1'b0;
      en_z_q   <= 1'b0;
      we_x_q   <= 4'h0;
      we_y_q   <= 4'h0;
      we_z_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      half_q   <= half_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      hz_q     <= hz_d;
      poll_q   <= poll_d;
      chk_q    <= chk_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      bz_q     <= bz_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      addr_z_q <= addr_z_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_z_q   <= wr_z_d;
      en_x_q   <= en_x_d;
      en_y_q   <= en_y_d;
      en_z_q   <= en_z_d;
      we_x_q   <= we_x_d;
      we_y_q   <= we_y_d;
      we_z_q   <= we_z_d;
    end
  end

endmodule

// File: tb/tb_point_cloud_loader.sv
// Directed bench for point_cloud_loader with a behavioural three-BRAM model on the second port.
module tb_point_cloud_loader;
  localparam int unsigned N    = 16;
  localparam int unsigned BUS  = 32;
  localparam int unsigned MAXP = 10;
  localparam int unsigned POLL = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  point_cloud_loader_if #(.N(N)) strm ();

  logic            unload_done, busy;
  logic [31:0]     addr_x, addr_y, addr_z;
  logic [BUS-1:0]  write_in_x, write_in_y, write_in_z;
  logic [BUS-1:0]  read_out_x, read_out_y, read_out_z;
  logic            en_x, en_y, en_z;
  logic [3:0]      we_x, we_y, we_z;

  point_cloud_loader #(
    .N(N), .BUS_SIZE(BUS), .MAX_POINTS(MAXP), .POLL_INTERVAL(POLL)
  ) dut (
    .clock(clock), .reset(reset), .strm(strm),
    .unload_done(unload_done), .busy(busy),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
    .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z)
  );

  // BRAM model: one-cycle read latency, plus a bench-side poke port for host/engine writes.
  logic [BUS-1:0] mem_x [0:15] = '{default: '0};
  logic [BUS-1:0] mem_y [0:15] = '{default: '0};
  logic [BUS-1:0] mem_z [0:15] = '{default: '0};
  logic           poke_en = 1'b0;
  logic [3:0]     poke_addr = '0;
  logic [2:0]     poke_mask = '0;
  logic [BUS-1:0] poke_dx = '0, poke_dy = '0, poke_dz = '0;
  int             cyc = 0, hdr_x_t = 0, hdr_y_t = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (en_x) begin
      if (we_x == 4'hf) mem_x[addr_x[3:0]] <= write_in_x;
      else              read_out_x <= mem_x[addr_x[3:0]];
    end
    if (en_y) begin
      if (we_y == 4'hf) mem_y[addr_y[3:0]] <= write_in_y;
      else              read_out_y <= mem_y[addr_y[3:0]];
    end
    if (en_z) begin
      if (we_z == 4'hf) mem_z[addr_z[3:0]] <= write_in_z;
      else              read_out_z <= mem_z[addr_z[3:0]];
    end
    if (en_x && we_x == 4'hf && addr_x == 32'd0) hdr_x_t <= cyc;
    if (en_y && we_y == 4'hf && addr_y == 32'd0 && write_in_y == 32'd1) hdr_y_t <= cyc;
    if (poke_en) begin
      if (poke_mask[0]) mem_x[poke_addr] <= poke_dx;
      if (poke_mask[1]) mem_y[poke_addr] <= poke_dy;
      if (poke_mask[2]) mem_z[poke_addr] <= poke_dz;
    end
  end

  logic rand_rdy = 1'b0;
  always @(posedge clock) begin
    #1;
    strm.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [2:0] m,
                      input logic [BUS-1:0] dx, input logic [BUS-1:0] dy,
                      input logic [BUS-1:0] dz);
    poke_addr = a;
    poke_mask = m;
    poke_dx   = dx;
    poke_dy   = dy;
    poke_dz   = dz;
    poke_en   = 1'b1;
    @(posedge clock);
    #1 poke_en = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int z, input bit last);
    strm.s_x     = N'(x);
    strm.s_y     = N'(y);
    strm.s_z     = N'(z);
    strm.s_last  = last;
    strm.s_valid = 1'b1;
    chk("s_ready_load", strm.s_ready, 1'b1);
    @(posedge clock);
    #1;
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
  endtask

  // Point i of a cloud with base b is (b+i, 0x100+b+i, 0x200+b+i).
  task automatic load(input int n, input bit last, input int b);
    for (int i = 0; i < n; i++) send(b + i, 'h100 + b + i, 'h200 + b + i, last && (i == n - 1));
  endtask

  task automatic wait_hdr();
    int w = 0;
    while (mem_y[0] !== 32'd1 && w < 40) begin
      @(posedge clock);
      #1;
      w++;
    end
    chk("hdr_start_flag", mem_y[0], 32'd1);
  endtask

  task automatic run_unload(input int n_exp, input int b, input int zero_idx, input bit drop);
    int got = 0, idx = 0, dones = 0, n = 0;
    bit stall = 1'b0;
    logic [N-1:0] px = '0, py = '0, pz = '0, ex, ey, ez;
    while (dones == 0 && n < 400) begin
      @(negedge clock);
      n++;
      if (stall) begin
        chk("stall_valid", strm.m_valid, 1'b1);
        chk("stall_x", strm.m_x, px);
        chk("stall_y", strm.m_y, py);
        chk("stall_z", strm.m_z, pz);
      end
      if (strm.m_valid && strm.m_ready) begin
        if (drop && idx == zero_idx) idx++;
        ex = (idx == zero_idx) ? '0 : N'(b + idx);
        ey = (idx == zero_idx) ? '0 : N'('h100 + b + idx);
        ez = (idx == zero_idx) ? '0 : N'('h200 + b + idx);
        chk("out_x", strm.m_x, ex);
        chk("out_y", strm.m_y, ey);
        chk("out_z", strm.m_z, ez);
        idx++;
        got++;
      end
      stall = strm.m_valid && !strm.m_ready;
      px    = strm.m_x;
      py    = strm.m_y;
      pz    = strm.m_z;
      if (unload_done) dones++;
    end
    repeat (3) begin
      @(negedge clock);
      if (unload_done) dones++;
      chk("post_done_valid", strm.m_valid, 1'b0);
    end
    chk("out_count", got, n_exp);
    chk("unload_done_once", dones, 1);
    chk("clear_z0", mem_z[0], 32'd0);
    chk("clear_y0", mem_y[0], 32'd0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int lat, w;
    reset        = 1'b1;
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
    strm.s_x     = '0;
    strm.s_y     = '0;
    strm.s_z     = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_ready", strm.s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", strm.m_valid, 1'b0);
    chk("rst_en_we", {en_x, en_y, en_z, we_x, we_y, we_z}, 15'h0);
    chk("rst_addr_x", addr_x, 32'd0);
    chk("rst_unload_done", unload_done, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Four points with s_last: packed words, header, start flag last, parked in WAIT_DONE.
    load(4, 1'b1, 1);
    wait_hdr();
    chk("t1_x1", mem_x[1], 32'h0002_0001);
    chk("t1_x2", mem_x[2], 32'h0004_0003);
    chk("t1_y1", mem_y[1], 32'h0102_0101);
    chk("t1_z2", mem_z[2], 32'h0204_0203);
    chk("t1_x0", mem_x[0], 32'd4);
    chk("t1_hdr_order", (hdr_y_t > hdr_x_t), 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_no_accept", strm.s_ready, 1'b0);

    // Done marker 100 cycles into WAIT_DONE; output must start within POLL+3 cycles.
    repeat (100) @(posedge clock);
    #1;
    chk("t3_still_waiting", strm.m_valid, 1'b0);
    poke(4'd0, 3'b100, '0, '0, 32'h0000_0fff);
    lat = 0;
    while (!strm.m_valid && lat < int'(POLL) + 3) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("t3_poll_latency", strm.m_valid, 1'b1);
    run_unload(4, 1, -1, 1'b0);

    // Odd count: final word zero-padded, exactly three points out.
    load(3, 1'b1, 5);
    wait_hdr();
    chk("t2_x2", mem_x[2], 32'h0000_0007);
    chk("t2_x1", mem_x[1], 32'h0006_0005);
    chk("t2_x0", mem_x[0], 32'd3);
    poke(4'd0, 3'b100, '0, '0, 32'h0000_0fff);
    run_unload(3, 5, -1, 1'b0);

    // Nine points with a randomly stalling sink.
    load(9, 1'b1, 10);
    wait_hdr();
    chk("t4_x0", mem_x[0], 32'd9);
    chk("t4_x5", mem_x[5], 32'h0000_0012);
    rand_rdy = 1'b1;
    poke(4'd0, 3'b100, '0, '0, 32'h0000_0fff);
    run_unload(9, 10, -1, 1'b0);
    rand_rdy = 1'b0;

    // MAX_POINTS reached without s_last ends the load.
    load(MAXP, 1'b0, 20);
    wait_hdr();
    chk("tmax_x0", mem_x[0], 32'd10);
    chk("tmax_x5", mem_x[5], 32'h001d_001c);
    chk("tmax_no_accept", strm.s_ready, 1'b0);

    // Reset in the middle of the unload.
    poke(4'd0, 3'b100, '0, '0, 32'h0000_0fff);
    w = 0;
    while (!(strm.m_valid && strm.m_ready) && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("t6_unload_started", strm.m_valid && strm.m_ready, 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("t6_m_valid", strm.m_valid, 1'b0);
    chk("t6_en_we", {en_x, en_y, en_z, we_x, we_y, we_z}, 15'h0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_s_ready", strm.s_ready, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    poke(4'd0, 3'b010, '0, '0, '0);

    // Fresh load after reset; engine zeroes point 1 (high half of word 1).
    load(4, 1'b1, 40);
    wait_hdr();
    chk("t5_x0", mem_x[0], 32'd4);
    poke(4'd1, 3'b111, 32'h0000_0028, 32'h0000_0128, 32'h0000_0228);
    poke(4'd0, 3'b100, '0, '0, 32'h0000_0fff);
`ifdef DROP_OUTLIERS_EN
    run_unload(3, 40, 1, 1'b1);
`else
    run_unload(4, 40, 1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
